// File: rtl/result_streamer.sv
// result_streamer: buffers completed 2x2 products {tag, result} in a small
// FIFO and serialises each one as four elements (C11, C12, C21, C22) on a
// valid/ready stream. Results arriving while the buffer is full are dropped
// and flagged by a sticky overflow bit.
module result_streamer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned TAG_W  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [4*ELEM_W-1:0] result_in,
    input  logic [TAG_W-1:0]    tag_in,
    input  logic                result_valid,
    output logic [ELEM_W-1:0]   out_data,
    output logic [1:0]          out_index,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                fifo_full,
    output logic                overflow,
    output logic [7:0]          results_sent
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned RES_W   = 4 * ELEM_W;
    localparam int unsigned ENTRY_W = TAG_W + RES_W;
    localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_fifo_full;
    logic               r_overflow;

    // Output side
    state_t             r_state;
    logic [RES_W-1:0]   r_hold;
    logic [ELEM_W-1:0]  r_out_data;
    logic [1:0]         r_out_index;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_valid;
    logic               r_out_last;
    logic [7:0]         r_results_sent;

    logic [ENTRY_W-1:0] w_head;
    logic [TAG_W-1:0]   w_head_tag;
    logic [RES_W-1:0]   w_head_res;
    logic               w_accept;
    logic               w_last_acc;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [1:0]         w_next_idx;
    logic [ELEM_W-1:0]  w_next_elem;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_tag = w_head[ENTRY_W-1 -: TAG_W];
    assign w_head_res = w_head[RES_W-1:0];

    // Handshake, pop/push decisions and next occupancy.
    // A pop frees a slot in the same edge, so a full FIFO still takes a write
    // when the holding register is reloaded in that cycle.
    always_comb begin
        w_accept    = r_out_valid && out_ready;
        w_last_acc  = (r_state == SEND) && w_accept && (r_out_index == 2'd3);
        w_pop       = (r_count != '0) && ((r_state == IDLE) || w_last_acc);
        w_push      = result_valid && ((r_count != L_DEPTH) || w_pop);
        w_drop      = result_valid && !w_push;
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    // Element that follows the one currently presented
    always_comb begin
        w_next_idx  = r_out_index + 2'd1;
        w_next_elem = '0;
        case (w_next_idx)
            2'd0:    w_next_elem = r_hold[4*ELEM_W-1 -: ELEM_W];
            2'd1:    w_next_elem = r_hold[3*ELEM_W-1 -: ELEM_W];
            2'd2:    w_next_elem = r_hold[2*ELEM_W-1 -: ELEM_W];
            default: w_next_elem = r_hold[ELEM_W-1:0];
        endcase
    end

    // FIFO data array write (no reset needed; occupancy guards reads)
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {tag_in, result_in};
        end
    end

    // FIFO pointers, occupancy, full flag and sticky overflow
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_fifo_full <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_nxt;
            r_fifo_full <= (w_count_nxt == L_DEPTH);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Serialiser FSM: loads the FIFO head and walks its four elements
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_hold         <= '0;
            r_out_data     <= '0;
            r_out_index    <= '0;
            r_out_tag      <= '0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_results_sent <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    if (w_pop) begin
                        r_hold      <= w_head_res;
                        r_out_tag   <= w_head_tag;
                        r_out_data  <= w_head_res[RES_W-1 -: ELEM_W];
                        r_out_index <= 2'd0;
                        r_out_last  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        if (r_out_index == 2'd3) begin
                            r_results_sent <= r_results_sent + 8'd1;
                            if (w_pop) begin
                                r_hold      <= w_head_res;
                                r_out_tag   <= w_head_tag;
                                r_out_data  <= w_head_res[RES_W-1 -: ELEM_W];
                                r_out_index <= 2'd0;
                                r_out_last  <= 1'b0;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
                                r_state     <= IDLE;
                            end
                        end else begin
                            r_out_index <= w_next_idx;
                            r_out_data  <= w_next_elem;
                            r_out_last  <= (w_next_idx == 2'd3);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_data     = r_out_data;
    assign out_index    = r_out_index;
    assign out_tag      = r_out_tag;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign fifo_full    = r_fifo_full;
    assign overflow     = r_overflow;
    assign results_sent = r_results_sent;

endmodule

// File: doc/result_streamer.md
Name: result_streamer

Overview:
Downstream stage of the matrix multiplier top level. Captures each completed 2x2 product (32-bit packed result plus 8-bit result count/tag) into a small FIFO. Serializes each result into four 8-bit elements on a valid/ready byte stream for the output/display side. Absorbs back-pressure and flags results that are dropped because the buffer is full.

Parameters:
DEPTH, 4, FIFO entries of {tag, result}; power of two, minimum 2
ELEM_W, 8, width of one result element
TAG_W, 8, width of result count/tag

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
result_in  input  32  packed 2x2 result: [31:24]=C11, [23:16]=C12, [15:8]=C21, [7:0]=C22
tag_in  input  8  result count/address accompanying result_in
result_valid  input  1  one-cycle strobe: result_in/tag_in valid this cycle
out_data  output  8  current element
out_index  output  2  element index 0..3 (0=C11 ... 3=C22)
out_tag  output  8  tag of the result being streamed
out_valid  output  1  out_data/out_index/out_tag/out_last valid
out_ready  input  1  consumer accepts element when out_valid && out_ready
out_last  output  1  high with element index 3
fifo_full  output  1  FIFO occupancy == DEPTH
overflow  output  1  sticky: a result was dropped
results_sent  output  8  count of fully transmitted results, wraps 255->0

Behaviour:
- Reset (reset=0, async): FIFO pointers/occupancy=0; FSM=IDLE; out_valid=0, out_last=0, out_data=0, out_index=0, out_tag=0, fifo_full=0, overflow=0, results_sent=0. A result in flight is discarded; no partial stream resumes.
- FIFO write: on a rising edge with result_valid=1 and (occupancy<DEPTH or pop this cycle), {tag_in, result_in} is written at the tail.
- Write with occupancy==DEPTH and no pop in the same cycle: data dropped; overflow set to 1 and held until reset. FIFO contents unchanged.
- Simultaneous write and pop at occupancy==DEPTH: both occur; occupancy stays DEPTH.
- Simultaneous write and pop at any other occupancy: occupancy unchanged.
- Pointers wrap modulo DEPTH.
- fifo_full is registered from the next-state occupancy.
- FSM has two states, IDLE and SEND.
- IDLE:
  - out_valid=0.
  - If occupancy>0: pop head into the output holding register, set out_index=0 and out_valid=1, go to SEND.
  - Latency: result_valid at edge N into an empty FIFO in IDLE gives out_valid=1 after edge N+1, i.e. the first element is visible 2 cycles after the strobe.
- SEND:
  - out_data = element[out_index] of the held result; out_tag = held tag; out_last = (out_index==3).
  - out_valid && !out_ready: all outputs hold stable.
  - Accepted element with index<3: out_index increments next cycle.
  - Accepted element with index==3: results_sent increments (mod 256).
    - If occupancy>0: pop next entry in the same edge; out_index=0, out_valid stays 1 (no bubble between results).
    - Otherwise: go to IDLE, out_valid=0.
- Total capacity before a drop is DEPTH entries plus one result in the holding register.
- out_ready is ignored while out_valid=0.
- Elements are unsigned and pass through unmodified; no arithmetic on data.

Test Plan:
- Single result: result_in=0x0A141E28, tag_in=0x03, strobe at cycle 0, out_ready=1 -> out_valid from cycle 2; out_data 0x0A,0x14,0x1E,0x28 on cycles 2-5; out_index 0-3; out_tag=0x03; out_last only on cycle 5; results_sent=1; out_valid=0 on cycle 6.
- Back-pressure: same result, out_ready=0 for cycles 2-4 then 1 -> out_data holds 0x0A for cycles 2-5; remaining elements follow in order; no element lost or duplicated.
- Back-to-back: three strobes on consecutive cycles (tags 1,2,3), out_ready=1 -> 12 elements on consecutive cycles, no out_valid gap, tags 1,2,3 in order, results_sent=3.
- Overflow: out_ready=0, six strobes on consecutive cycles (tags 1-6) -> fifo_full=1 after the fifth strobe; tag 6 dropped; overflow=1. Release out_ready -> tags 1-5 stream in order; overflow stays 1.
- Full + simultaneous pop: FIFO full, strobe issued on the cycle the last element of the held result is accepted -> new entry accepted, overflow stays 0, fifo_full stays 1.
- Reset mid-stream: assert reset (0) during element index 2, asynchronously between edges -> out_valid, fifo_full and overflow go 0 immediately; results_sent=0. After release, a new strobe streams from index 0 with correct data.
- Counter wrap: 256 results sent -> results_sent reads 0x00; the next result makes it 0x01.
